// File: rtl/adder_pkg.sv
// Shared constants and types for the unsigned ripple-carry adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Result type for the default width: one extra bit holds the carry-out.
    typedef logic [DEFAULT_WIDTH:0] sum_t;

endpackage : adder_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder; WIDTH of these are chained to form the ripple-carry sum.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule : full_adder_cell

// File: rtl/async_adder.sv
// Unsigned adder: combinational ripple-carry SUM plus a one-cycle registered copy
// (sum_q, carry_q, out_valid) for synchronous consumers.
module async_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    output logic [WIDTH:0]   SUM,
    output logic [WIDTH:0]   sum_q,
    output logic             carry_q,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum_bits;
    logic [WIDTH:0]   w_sum_p0;

    assign w_carry[0] = 1'b0;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ripple
        full_adder_cell u_fa (
            .a    (A[g]),
            .b    (B[g]),
            .cin  (w_carry[g]),
            .s    (w_sum_bits[g]),
            .cout (w_carry[g+1])
        );
    end

    // Stage p0: combinational result, visible on SUM with no clock involvement
    assign w_sum_p0 = {w_carry[WIDTH], w_sum_bits};
    assign SUM      = w_sum_p0;

    logic [WIDTH:0] r_sum_p1;
    logic           r_carry_p1;
    logic           r_vld_p1;

    // Stage p1: capture on in_valid; reset takes priority over capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_p1   <= '0;
            r_carry_p1 <= 1'b0;
            r_vld_p1   <= 1'b0;
        end else if (in_valid) begin
            r_sum_p1   <= w_sum_p0;
            r_carry_p1 <= w_carry[WIDTH];
            r_vld_p1   <= 1'b1;
        end else begin
            r_vld_p1   <= 1'b0;
        end
    end

    assign sum_q     = r_sum_p1;
    assign carry_q   = r_carry_p1;
    assign out_valid = r_vld_p1;

endmodule : async_adder

// File: tb/tb_async_adder.sv
// Self-checking bench for async_adder: directed cases then randomized traffic vs. a plain-arithmetic model.
module tb_async_adder;
    import adder_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         in_valid;
    logic [W:0]   SUM;
    logic [W:0]   sum_q;
    logic         carry_q;
    logic         out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state for the registered side
    int m_q   = 0;
    int m_c   = 0;
    int m_vld = 0;

    async_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .SUM       (SUM),
        .sum_q     (sum_q),
        .carry_q   (carry_q),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Called #1 after a rising edge: drive, check SUM, clock once, check registered outputs.
    task automatic cycle(input int a, input int b, input int v, input int r);
        A        = a[W-1:0];
        B        = b[W-1:0];
        in_valid = v[0];
        rst      = r[0];
        #1;
        chk("SUM", 32'(SUM), a + b);
        @(posedge clk);
        if (r != 0) begin
            m_q = 0; m_c = 0; m_vld = 0;
        end else if (v != 0) begin
            m_q = a + b; m_c = (a + b >= (1 << W)) ? 1 : 0; m_vld = 1;
        end else begin
            m_vld = 0;
        end
        #1;
        chk("sum_q",     32'(sum_q),     m_q);
        chk("carry_q",   32'(carry_q),   m_c);
        chk("out_valid", 32'(out_valid), m_vld);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum_q",     32'(sum_q),     0);
        chk("rst_carry_q",   32'(carry_q),   0);
        chk("rst_out_valid", 32'(out_valid), 0);

        // Combinational path, sampled without waiting for an edge
        rst = 1'b0;
        A = 4'd1;  B = 4'd2;  #2; chk("comb_1_2",   32'(SUM), 3);
        A = 4'd5;  B = 4'd3;  #2; chk("comb_5_3",   32'(SUM), 8);
        A = 4'd10; B = 4'd5;  #2; chk("comb_10_5",  32'(SUM), 15);
        chk("comb_nocarry", 32'(SUM[W]), 0);
        A = 4'd15; B = 4'd1;  #2; chk("comb_15_1",  32'(SUM), 16);
        chk("comb_carry", 32'(SUM[W]), 1);
        A = 4'd15; B = 4'd15; #2; chk("comb_15_15", 32'(SUM), 30);

        @(posedge clk); #1;
        m_q = 0; m_c = 0; m_vld = 0;

        // Reset held with max operands; SUM still tracks
        cycle(15, 15, 0, 1);
        cycle(15, 15, 1, 1);
        // Single capture, then hold
        cycle(15, 1, 1, 0);
        cycle(15, 1, 0, 0);
        chk("hold_16", 32'(sum_q), 16);
        // Reset beats in_valid, then back-to-back captures
        cycle(7, 2, 1, 1);
        cycle(7, 2, 1, 0);
        cycle(8, 8, 1, 0);
        chk("b2b_vld", 32'(out_valid), 1);
        cycle(0, 0, 0, 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
                  ($urandom_range(0, 3) != 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_async_adder
